// File: rtl/regfile_wr_arb_pkg.sv
// Shared types and widths for the register-bank write-port arbiter.
// Optional conflict counter is enabled by REGFILE_ARB_CONFLICT_CNT_EN (see regfile_wr_arb).
package regfile_wr_arb_pkg;

    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned COUNTER_W  = 16;

    // Identity of the requester that won the most recent transfer
    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

endpackage

// File: rtl/regfile_wr_arb_if.sv
// Requester handshakes (A = ALU writeback, B = load return) and the write bus to the reg32 bank.
interface regfile_wr_arb_if #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
);
    import regfile_wr_arb_pkg::*;

    logic                  a_valid;
    logic [AW-1:0]         a_addr;
    logic [REG_DATA_W-1:0] a_data;
    logic                  a_ready;
    logic                  b_valid;
    logic [AW-1:0]         b_addr;
    logic [REG_DATA_W-1:0] b_data;
    logic                  b_ready;
    logic [NREGS-1:0]      wr_en;
    logic [REG_DATA_W-1:0] wr_d;
    logic                  addr_err;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, wr_en, wr_d, addr_err
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, wr_en, wr_d, addr_err
    );

endinterface

// File: rtl/regfile_wr_arb_rr_arb2.sv
// Two-input round-robin arbiter; gnt_c[0] = A, gnt_c[1] = B, never both set.
// last_gnt resets to B so A wins the first conflict, and moves only on a transfer.
module regfile_wr_arb_rr_arb2
    import regfile_wr_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic       b_valid,
    output logic [1:0] gnt_c
);

    gnt_e last_gnt;
    logic gnt_a_c;
    logic gnt_b_c;

    // Grant is suppressed during reset so no handshake completes while rst is high
    always_comb begin
        gnt_a_c = 1'b0;
        gnt_b_c = 1'b0;
        if (!rst) begin
            gnt_a_c = a_valid && (!b_valid || (last_gnt == GNT_B));
            gnt_b_c = b_valid && (!a_valid || (last_gnt == GNT_A));
        end
    end

    assign gnt_c = {gnt_b_c, gnt_a_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= GNT_B;
        end else if (gnt_a_c) begin
            last_gnt <= GNT_A;
        end else if (gnt_b_c) begin
            last_gnt <= GNT_B;
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Write-port controller for the reg32 bank: round-robin A/B grant, registered one-hot wr_en + wr_d.
// Define REGFILE_ARB_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module regfile_wr_arb
    import regfile_wr_arb_pkg::*;
#(
    parameter int unsigned NREGS   = 32,
    parameter int unsigned AW      = 5,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arb_if.slave      bus
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    ,
    output logic [COUNTER_W-1:0] conflict_cnt
`endif
);

    logic [1:0]            gnt_c;
    logic                  xfer_c;
    logic [AW-1:0]         sel_addr_c;
    logic [REG_DATA_W-1:0] sel_data_c;
    logic                  in_range_c;
    logic                  drop_r0_c;
    logic [NREGS-1:0]      onehot_c;

    logic [NREGS-1:0]      wr_en_q;
    logic [REG_DATA_W-1:0] wr_d_q;
    logic                  addr_err_q;

    regfile_wr_arb_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .a_valid (bus.a_valid),
        .b_valid (bus.b_valid),
        .gnt_c   (gnt_c)
    );

    assign bus.a_ready = gnt_c[0];
    assign bus.b_ready = gnt_c[1];

    // Select the granted request and decode it, masking out-of-range and r0 writes
    always_comb begin
        xfer_c     = gnt_c[0] || gnt_c[1];
        sel_addr_c = gnt_c[0] ? bus.a_addr : bus.b_addr;
        sel_data_c = gnt_c[0] ? bus.a_data : bus.b_data;
        in_range_c = 32'(sel_addr_c) < 32'(NREGS);
        drop_r0_c  = ZERO_R0 && (sel_addr_c == '0);
        onehot_c   = '0;
        if (xfer_c && in_range_c && !drop_r0_c) begin
            onehot_c = NREGS'(1) << sel_addr_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q    <= '0;
            wr_d_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            wr_en_q <= onehot_c;
            if (xfer_c) begin
                wr_d_q <= sel_data_c;
            end
            if (xfer_c && !in_range_c) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_d     = wr_d_q;
    assign bus.addr_err = addr_err_q;

`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    // Cycles where both requesters contend, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (bus.a_valid && bus.b_valid && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + COUNTER_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Self-checking bench for regfile_wr_arb (NREGS=32, AW=6, ZERO_R0=1) with a modelled reg32 bank.
module tb_regfile_wr_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wr_arb_if #(.NREGS(32), .AW(6)) bus ();

`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    regfile_wr_arb #(.NREGS(32), .AW(6), .ZERO_R0(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Register bank: each reg32 captures wr_d when its enable is high
    logic [31:0] bank [32];
    initial for (int i = 0; i < 32; i++) bank[i] = 32'h0;
    always @(posedge clk) begin
        for (int i = 0; i < 32; i++) if (bus.wr_en[i]) bank[i] <= bus.wr_d;
    end

    typedef struct {
        logic        av;
        logic [5:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [5:0]  ba;
        logic [31:0] bd;
        logic        ea;
        logic        eb;
    } vec_t;

    typedef struct {
        logic [31:0] en;
        logic [31:0] d;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] m_d   = 32'h0;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, check ready, push expected write, then compare after the edge
    task automatic step(input vec_t v, input string tag);
        exp_t        e;
        logic [5:0]  ad;
        logic [31:0] dd;
        exp_t        got;
        bus.a_valid = v.av; bus.a_addr = v.aa; bus.a_data = v.ad;
        bus.b_valid = v.bv; bus.b_addr = v.ba; bus.b_data = v.bd;
        #2;
        chk({tag, " a_ready"}, 32'(bus.a_ready), 32'(v.ea));
        chk({tag, " b_ready"}, 32'(bus.b_ready), 32'(v.eb));
        e.en = 32'h0;
        if (v.ea || v.eb) begin
            ad  = v.ea ? v.aa : v.ba;
            dd  = v.ea ? v.ad : v.bd;
            m_d = dd;
            if (ad >= 6'd32) m_err = 1'b1;
            else if (ad != 6'd0) e.en = 32'h1 << ad;
        end
        e.d   = m_d;
        e.err = m_err;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'h1, 32'h0);
        end else begin
            got = sbq.pop_front();
            chk({tag, " wr_en"}, bus.wr_en, got.en);
            chk({tag, " wr_d"}, bus.wr_d, got.d);
            chk({tag, " addr_err"}, 32'(bus.addr_err), 32'(got.err));
        end
    endtask

    vec_t vecs [16];
    vec_t hv;

    initial begin
        vecs[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0};
        vecs[1]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd0,  32'h0000B000, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 6'd3,  32'hA3000001, 1'b1, 6'd7,  32'hB7000001, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 6'd3,  32'hA3000002, 1'b1, 6'd7,  32'hB7000001, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 6'd3,  32'hA3000002, 1'b1, 6'd7,  32'hB7000002, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 6'd3,  32'hA3000003, 1'b1, 6'd7,  32'hB7000002, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 6'd3,  32'hA3000003, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0};
        vecs[8]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd31, 32'h1F1F1F1F, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 6'd40, 32'h40404040, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0};
        vecs[10] = '{1'b1, 6'd12, 32'h00000A12, 1'b1, 6'd12, 32'h00000B12, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 6'd12, 32'h00000A12, 1'b1, 6'd1,  32'h00000011, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd1,  32'h00000011, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 6'd32, 32'h32323232, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0};
        vecs[14] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,        1'b0, 1'b0};
        vecs[15] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,        1'b0, 1'b0};

        // Reset with both requesters valid
        rst = 1'b1;
        bus.a_valid = 1'b1; bus.a_addr = 6'd3; bus.a_data = 32'h11111111;
        bus.b_valid = 1'b1; bus.b_addr = 6'd7; bus.b_data = 32'h22222222;
        #2;
        chk("rst a_ready", 32'(bus.a_ready), 32'h0);
        chk("rst b_ready", 32'(bus.b_ready), 32'h0);
        chk("rst wr_en", bus.wr_en, 32'h0);
        chk("rst wr_d", bus.wr_d, 32'h0);
        chk("rst addr_err", 32'(bus.addr_err), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst held wr_en", bus.wr_en, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i], $sformatf("v%0d", i));
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
            if (i == 6) chk("conflict_cnt", 32'(conflict_cnt), 32'd4);
`endif
        end

        chk("bank r5", bank[5], 32'hDEADBEEF);
        chk("bank r3", bank[3], 32'hA3000003);
        chk("bank r7", bank[7], 32'hB7000002);
        chk("bank r31", bank[31], 32'h1F1F1F1F);
        chk("bank r12 later grant", bank[12], 32'h00000A12);
        chk("bank r1", bank[1], 32'h00000011);
        chk("bank r0", bank[0], 32'h0);

        // Reset mid-cycle right after a transfer to r9: the in-flight write is lost
        bus.a_valid = 1'b1; bus.a_addr = 6'd9; bus.a_data = 32'h99999999;
        bus.b_valid = 1'b0;
        #2;
        chk("r9 a_ready", 32'(bus.a_ready), 32'h1);
        @(posedge clk); #1;
        chk("r9 wr_en", bus.wr_en, 32'h00000200);
        chk("r9 wr_d", bus.wr_d, 32'h99999999);
        bus.a_valid = 1'b0;
        #2;
        rst = 1'b1;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        #1;
        chk("midrst wr_en", bus.wr_en, 32'h0);
        chk("midrst wr_d", bus.wr_d, 32'h0);
        chk("midrst addr_err", 32'(bus.addr_err), 32'h0);
        chk("midrst a_ready", 32'(bus.a_ready), 32'h0);
        chk("midrst b_ready", 32'(bus.b_ready), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst bank r9", bank[9], 32'h0);
        rst   = 1'b0;
        m_d   = 32'h0;
        m_err = 1'b0;
        sbq.delete();

        // Requester re-presents after reset
        hv = '{1'b1, 6'd9, 32'h12345678, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0};
        step(hv, "re r9");
        hv = '{1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0};
        step(hv, "re idle");
        chk("re bank r9", bank[9], 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
